// File: rtl/mem_port_arbiter_pkg.sv
// Shared state and owner encodings for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t IBUSY = 2'd1;
    localparam state_t DBUSY = 2'd2;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int BURST_W = 4;

    function automatic owner_e state_owner(input state_t s);
        return (s == DBUSY) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and data ports,
// one registered transaction at a time, with a burst limit that protects fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_DBURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,

    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_stall_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_stall_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_DBURST);

    state_t              state_q, state_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic                i_elig, d_elig;
    logic                d_wins, i_wins;

    // A port in its own ack cycle is not eligible, so a request held over the ack is not re-granted.
    assign i_elig = start_i & i_req_i & ~i_ack_q;
    assign d_elig = start_i & d_req_i & ~d_ack_q;
    assign d_wins = d_elig & ~(i_elig & (burst_q == BURST_LIMIT));
    assign i_wins = i_elig & ~d_wins;

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (d_wins) begin
                    state_d     = DBUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    if (!i_req_i) begin
                        burst_d = '0;
                    end else if (burst_q != BURST_LIMIT) begin
                        burst_d = burst_q + 1'b1;
                    end
                end else if (i_wins) begin
                    state_d    = IBUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr_i;
                    burst_d    = '0;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_owner(state_q) == OWN_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_rdata_i;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata_i;
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            burst_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign i_ack_o     = i_ack_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_ack_o     = d_ack_q;
    assign d_rdata_o   = d_rdata_q;

    // Stalls are forced low while reset is asserted so every output reads 0 in reset.
    assign i_stall_o = rst_i & i_req_i & ~i_ack_q;
    assign d_stall_o = rst_i & d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: port requesters, a wait-state memory model and
// queues of expected memory transactions and acks.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    logic        i_ack, i_stall, d_ack, d_stall;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int          mem_waits = 0;
    logic        mem_hold = 1'b0;
    int          wait_cnt = 0;

    int          checks = 0;
    int          errors = 0;
    int          mem_txn = 0;
    logic        prev_done = 1'b0;
    logic [31:0] d_last_rd = '0;
    logic        i_linger = 1'b0;
    logic        i_drop = 1'b0;
    logic        mask_start = 1'b0;

    logic [31:0] i_todo[$];
    txn_t        d_todo[$];
    logic [31:0] exp_i[$];
    txn_t        exp_d[$];
    txn_t        exp_mem[$];

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_DBURST(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .start_i    (start),
        .i_req_i    (i_req),
        .i_addr_i   (i_addr),
        .i_ack_o    (i_ack),
        .i_rdata_o  (i_rdata),
        .i_stall_o  (i_stall),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_ack_o    (d_ack),
        .d_rdata_o  (d_rdata),
        .d_stall_o  (d_stall),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_ack_i  (mem_ack),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h8C22_0004;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.we = we;
        t.addr = a;
        t.wdata = wd;
        return t;
    endfunction

    // Memory acks after mem_waits extra cycles of mem_req; zero waits ties ack to req.
    assign mem_ack   = mem_req && !mem_hold && (wait_cnt == mem_waits);
    assign mem_rdata = mem_ack ? mem_val(mem_addr) : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    task automatic req_i(input logic [31:0] a);
        i_todo.push_back(a);
        exp_i.push_back(mem_val(a));
    endtask

    task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_todo.push_back(mk(we, a, wd));
        exp_d.push_back(mk(we, a, wd));
    endtask

    // One clock: scoreboard at the falling edge, then requester updates.
    task automatic cycle();
        txn_t        e;
        logic [31:0] erd;
        @(negedge clk);
        if (prev_done) begin
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL mem_gap mem_req=%b required=0", mem_req);
            end
        end
        prev_done = mem_req && mem_ack;
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            mem_txn++;
            checks++;
            if (exp_mem.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected addr=%h we=%b required=none", mem_addr, mem_we);
            end else begin
                e = exp_mem.pop_front();
                if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL mem_txn we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                end
            end
        end
        if (i_ack === 1'b1) begin
            checks++;
            if (exp_i.size() == 0) begin
                errors++;
                $display("FAIL i_ack_unexpected rdata=%h required=none", i_rdata);
            end else begin
                erd = exp_i.pop_front();
                if (i_rdata !== erd) begin
                    errors++;
                    $display("FAIL i_rdata actual=%h required=%h", i_rdata, erd);
                end
            end
        end
        if (d_ack === 1'b1) begin
            checks++;
            if (exp_d.size() == 0) begin
                errors++;
                $display("FAIL d_ack_unexpected rdata=%h required=none", d_rdata);
            end else begin
                e = exp_d.pop_front();
                erd = e.we ? d_last_rd : mem_val(e.addr);
                if (d_rdata !== erd) begin
                    errors++;
                    $display("FAIL d_rdata we=%b actual=%h required=%h", e.we, d_rdata, erd);
                end
                if (!e.we) d_last_rd = erd;
            end
        end

        if (i_req === 1'b1 && i_ack === 1'b1) begin
            if (i_linger) i_drop = 1'b1;
            else          i_req = 1'b0;
        end else if (i_drop) begin
            i_req = 1'b0;
            i_drop = 1'b0;
            i_linger = 1'b0;
        end
        if (i_req !== 1'b1 && !i_drop && i_todo.size() > 0) begin
            i_addr = i_todo.pop_front();
            i_req = 1'b1;
        end
        if (d_req === 1'b1 && d_ack === 1'b1) d_req = 1'b0;
        if (d_req !== 1'b1 && d_todo.size() > 0) begin
            e = d_todo.pop_front();
            d_we = e.we;
            d_addr = e.addr;
            d_wdata = e.wdata;
            d_req = 1'b1;
        end
        // Holding start_i low over each data ack cycle makes both ports meet at every arbitration edge.
        if (mask_start) start = ~d_ack;
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((i_todo.size() + d_todo.size() + exp_i.size() + exp_d.size() + exp_mem.size() != 0
                || i_req === 1'b1 || d_req === 1'b1 || i_drop) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout pending_mem=%0d pending_i=%0d pending_d=%0d required=0",
                     name, exp_mem.size(), exp_i.size(), exp_d.size());
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) cycle();
        checks++;
        if ({i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs mem_req=%b mem_addr=%h i_ack=%b d_ack=%b required=all 0",
                     mem_req, mem_addr, i_ack, d_ack);
        end
        rst_n = 1'b1;
        cycle();
        cycle();
        checks++;
        if ({mem_req, i_ack, d_ack, i_stall, d_stall} !== 5'b0) begin
            errors++;
            $display("FAIL reset_release mem_req=%b i_ack=%b d_ack=%b required=0", mem_req, i_ack, d_ack);
        end
    endtask

    task automatic test_zero_wait_fetch();
        mem_waits = 0;
        start = 1'b1;
        req_i(32'h0000_0010);
        exp_mem.push_back(mk(1'b0, 32'h0000_0010, 32'h0));
        cycle();
        checks++;
        if ({i_ack, i_stall} !== 2'b01) begin
            errors++;
            $display("FAIL fetch_c0 ack=%b stall=%b required ack=0 stall=1", i_ack, i_stall);
        end
        cycle();
        checks++;
        if ({i_ack, i_stall, mem_req} !== 3'b011) begin
            errors++;
            $display("FAIL fetch_c1 ack=%b stall=%b mem_req=%b required 0 1 1", i_ack, i_stall, mem_req);
        end
        cycle();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h8C22_0004) begin
            errors++;
            $display("FAIL fetch_c2 ack=%b rdata=%h required ack=1 rdata=8c220004", i_ack, i_rdata);
        end
        cycle();
        checks++;
        if (i_ack !== 1'b0 || i_rdata !== 32'h8C22_0004 || i_stall !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c3 ack=%b rdata=%h stall=%b required ack=0 rdata=8c220004 stall=0",
                     i_ack, i_rdata, i_stall);
        end
    endtask

    task automatic test_simultaneous();
        mem_waits = 3;
        req_d(1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
        req_i(32'h0000_0040);
        exp_mem.push_back(mk(1'b1, 32'h0000_0020, 32'hDEAD_BEEF));
        exp_mem.push_back(mk(1'b0, 32'h0000_0040, 32'h0));
        drain("simultaneous", 40);
        checks++;
        if (d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL write_keeps_rdata actual=%h required=0", d_rdata);
        end
    endtask

    task automatic test_starvation();
        mem_waits = 0;
        mask_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                req_d(1'b0, 32'h0000_1000 + 32'((k * 4 + j) * 4), 32'h0);
                exp_mem.push_back(mk(1'b0, 32'h0000_1000 + 32'((k * 4 + j) * 4), 32'h0));
            end
            req_i(32'h0000_2000 + 32'(k * 4));
            exp_mem.push_back(mk(1'b0, 32'h0000_2000 + 32'(k * 4), 32'h0));
        end
        drain("starvation", 200);
        mask_start = 1'b0;
        start = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        mem_waits = 0;
        mem_hold = 1'b1;
        req_d(1'b0, 32'h0000_0300, 32'h0);
        exp_mem.push_back(mk(1'b0, 32'h0000_0300, 32'h0));
        while (mem_req !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_grant mem_req=%b required=1", mem_req);
        end
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs mem_req=%b mem_addr=%h d_rdata=%h i_rdata=%h required=all 0",
                     mem_req, mem_addr, d_rdata, i_rdata);
        end
        d_last_rd = '0;
        cycle();
        cycle();
        mem_hold = 1'b0;
        rst_n = 1'b1;
        cycle();
        checks++;
        if (d_ack !== 1'b0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_regrant d_ack=%b mem_req=%b required d_ack=0 mem_req=1", d_ack, mem_req);
        end
        drain("reset_mid", 20);
    endtask

    task automatic test_start_gating();
        start = 1'b0;
        req_d(1'b0, 32'h0000_0080, 32'h0);
        req_i(32'h0000_0084);
        exp_mem.push_back(mk(1'b0, 32'h0000_0080, 32'h0));
        exp_mem.push_back(mk(1'b0, 32'h0000_0084, 32'h0));
        cycle();
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if ({mem_req, i_stall, d_stall} !== 3'b011) begin
                errors++;
                $display("FAIL start_low c=%0d mem_req=%b i_stall=%b d_stall=%b required 0 1 1",
                         c, mem_req, i_stall, d_stall);
            end
        end
        start = 1'b1;
        cycle();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0080) begin
            errors++;
            $display("FAIL start_first_grant mem_req=%b addr=%h required mem_req=1 addr=00000080",
                     mem_req, mem_addr);
        end
        drain("start_gating", 20);
    endtask

    task automatic test_back_to_back_regrant_guard();
        int base;
        mem_waits = 0;
        base = mem_txn;
        i_linger = 1'b1;
        req_i(32'h0000_0100);
        exp_mem.push_back(mk(1'b0, 32'h0000_0100, 32'h0));
        drain("regrant_guard", 20);
        repeat (4) cycle();
        checks++;
        if (mem_txn - base != 1) begin
            errors++;
            $display("FAIL regrant_guard transactions=%0d required=1", mem_txn - base);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_start_gating();
        test_back_to_back_regrant_guard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached required=finish");
        $fatal(1);
    end

endmodule
